g_4rr_arb: RTL and testbench

//  Four-requester round-robin arbiter for schematic macro use. Requests are active-low,

---
 rtl/g_4rr_arb_pkg.sv | 24 ++
 rtl/g_4rr_arb_if.sv | 25 ++
 rtl/g_4rr_pick.sv | 38 +++
 rtl/g_4rr_arb.sv | 121 ++++++++++++
 tb/tb_g_4rr_arb.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/g_4rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// g_4rr_arb_pkg
// Shared definitions for the four-requester round-robin arbiter:
//   NREQ     number of requesters
//   state_t  arbiter FSM state encoding (ST_IDLE / ST_OWN)
//   onehot() index -> one-hot grant vector helper
// ---------------------------------------------------------------------------
package g_4rr_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/g_4rr_arb_if.sv
// ---------------------------------------------------------------------------
// g_4rr_arb_if
// Request/grant bundle between the bus masters and the arbiter.
//   CE    clock enable (low freezes the arbiter)
//   REQN  active-low requests, bit i = requester i
//   GNT   registered one-hot grant, active-high
//   GIDX  registered owner index, valid while BUSY=1
//   BUSY  registered, 1 while any GNT bit is set
//   ANY   combinational "any request pending"
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface g_4rr_arb_if;
    import g_4rr_arb_pkg::*;

    logic            CE;
    logic [NREQ-1:0] REQN;
    logic [NREQ-1:0] GNT;
    logic [1:0]      GIDX;
    logic            BUSY;
    logic            ANY;

    modport master (output CE, REQN, input GNT, GIDX, BUSY, ANY);
    modport slave  (input CE, REQN, output GNT, GIDX, BUSY, ANY);

endinterface

// File: rtl/g_4rr_pick.sv
// ---------------------------------------------------------------------------
// g_4rr_pick
// Combinational rotate-priority picker. Searches ptr+1, ptr+2, ptr+3, ptr
// (mod 4) and returns the first active requester.
//   req  in   4  active-high requests
//   ptr  in   2  last granted requester
//   win  out  2  winning index (0 when hit=0)
//   hit  out  1  at least one request active
// ---------------------------------------------------------------------------
module g_4rr_pick
    import g_4rr_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      win,
    output logic            hit
);

    logic [1:0] idx;

    // Walk the search order backwards so the highest-priority hit is the
    // last assignment and therefore the one that sticks.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        win = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/g_4rr_arb.sv
// ---------------------------------------------------------------------------
// g_4rr_arb
// Four-requester round-robin arbiter with active-low requests and a
// registered one-hot grant. A new owner is chosen on release (no idle
// bubble when others wait); the previous owner ranks last in the rotation.
//   CK    in   clock, rising edge
//   CD    in   asynchronous active-high clear
//   bus   slave modport of g_4rr_arb_if (CE, REQN, GNT, GIDX, BUSY, ANY)
// Parameters (timeout build only):
//   HOLD_MAX  max cycles an owner keeps the grant while others wait
//   CNT_W     hold-counter width, HOLD_MAX <= 2**CNT_W-1
// Optional feature: define G_ARB_TIMEOUT_EN to enable the hold timeout.
// ---------------------------------------------------------------------------
module g_4rr_arb
    import g_4rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic          CK,
    input  logic          CD,
    g_4rr_arb_if.slave    bus
);

    if (HOLD_MAX < 1 || HOLD_MAX > (2**CNT_W) - 1) begin : g_bad_hold
        $error("g_4rr_arb: HOLD_MAX must be in 1..2**CNT_W-1");
    end

    state_t          state;
    logic [1:0]      ptr;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gidx;
    logic            busy;

    logic [NREQ-1:0] req;
    logic [1:0]      win;
    logic            hit;
    logic            take;   // load the picker winner as the new owner
    logic            drop;   // owner released, nobody waiting

    assign req = ~bus.REQN;

    g_4rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .win (win),
        .hit (hit)
    );

`ifdef G_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    logic [CNT_W-1:0] cnt;
`endif

    always_comb begin
        take = 1'b0;
        drop = 1'b0;
        case (state)
            ST_IDLE: take = hit;
            ST_OWN: begin
                if (!req[ptr]) begin
                    // Owner's own bit is clear, so any hit is another requester.
                    take = hit;
                    drop = !hit;
                end
`ifdef G_ARB_TIMEOUT_EN
                else if (cnt == HOLD_LAST) begin
                    // Owner still requests; the picker only returns ptr
                    // when nobody else is waiting.
                    take = hit && (win != ptr);
                end
`endif
            end
            default: ;
        endcase
    end

    // NOTE: the asynchronous clear resets every register, including the
    // rotation pointer, so the first search after reset starts at requester 0.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state <= ST_IDLE;
            ptr   <= 2'd3;
            gnt   <= '0;
            gidx  <= '0;
            busy  <= 1'b0;
`ifdef G_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else if (bus.CE) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            if (take) begin
                state <= ST_OWN;
                ptr   <= win;
                gnt   <= onehot(win);
                gidx  <= win;
                busy  <= 1'b1;
`ifdef G_ARB_TIMEOUT_EN
                cnt   <= '0;
`endif
            end else if (drop) begin
                // ptr keeps the released owner so it ranks last next time.
                state <= ST_IDLE;
                gnt   <= '0;
                busy  <= 1'b0;
            end
`ifdef G_ARB_TIMEOUT_EN
            else if (state == ST_OWN && cnt != HOLD_LAST) begin
                cnt <= cnt + 1'b1;
            end
`endif
        end
    end

    assign bus.GNT  = gnt;
    assign bus.GIDX = gidx;
    assign bus.BUSY = busy;
    assign bus.ANY  = ~&bus.REQN;

endmodule

// File: tb/tb_g_4rr_arb.sv
// ---------------------------------------------------------------------------
// tb_g_4rr_arb
// Self-checking bench for g_4rr_arb. A behavioural model tracks the owner
// as an integer (-1 = none) and applies the round-robin rules directly.
// Define G_ARB_TIMEOUT_EN for both bench and RTL to exercise the timeout.
// ---------------------------------------------------------------------------
module tb_g_4rr_arb;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 4;
`ifdef G_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_BUILD = 1'b1;
`else
    localparam bit TIMEOUT_BUILD = 1'b0;
`endif

    logic CK = 1'b0;
    logic CD;

    g_4rr_arb_if bus ();

    always #5 CK = ~CK;

    g_4rr_arb #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .CK  (CK),
        .CD  (CD),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_owner;
    int m_ptr;
    int m_cnt;

    function automatic int search(input logic [3:0] req, input int ptr);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 3;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic [3:0] reqn, input logic ce);
        logic [3:0] req;
        int w;
        req = ~reqn;
        if (!ce) return;
        w = search(req, m_ptr);
        if (m_owner < 0 || !req[m_owner]) begin
            if (w >= 0) begin
                m_owner = w; m_ptr = w; m_cnt = 0;
            end else begin
                m_owner = -1;
            end
        end else if (TIMEOUT_BUILD) begin
            if (m_cnt == HOLD_MAX - 1 && w != m_owner) begin
                m_owner = w; m_ptr = w; m_cnt = 0;
            end else if (m_cnt < HOLD_MAX - 1) begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [3:0] exp_gnt();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    // Advance one clock: update model with the inputs the DUT will sample,
    // then sample DUT outputs 1 time unit after the edge.
    task automatic step();
        model_edge(bus.REQN, bus.CE);
        @(posedge CK);
        #1;
    endtask

    task automatic apply_reset();
        CD = 1'b1;
        #3;
        model_reset();
        @(posedge CK);
        #1;
        CD = 1'b0;
    endtask

    task automatic test_reset();
        bus.CE   = 1'b1;
        bus.REQN = 4'b1111;
        CD       = 1'b1;
        #12;
        checks++;
        if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0 || bus.GIDX !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: gnt=%b busy=%b gidx=%0d expected 0000/0/0",
                     bus.GNT, bus.BUSY, bus.GIDX);
        end
        model_reset();
        @(posedge CK);
        #1;
        CD = 1'b0;
        step();
        checks++;
        if (bus.GNT !== 4'b0000 || bus.ANY !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: gnt=%b any=%b expected 0000/0", bus.GNT, bus.ANY);
        end
    endtask

    task automatic test_first_grant();
        apply_reset();
        bus.REQN = 4'b1110;
        #1;
        checks++;
        if (bus.ANY !== 1'b1 || bus.GNT !== 4'b0000) begin
            failures++;
            $display("FAIL first_any: any=%b gnt=%b expected 1/0000", bus.ANY, bus.GNT);
        end
        step();
        checks++;
        if (bus.GNT !== 4'b0001 || bus.GIDX !== 2'd0 || bus.BUSY !== 1'b1) begin
            failures++;
            $display("FAIL first_grant: gnt=%b gidx=%0d busy=%b expected 0001/0/1",
                     bus.GNT, bus.GIDX, bus.BUSY);
        end
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        apply_reset();
        bus.REQN = 4'b0000;
        step();
        for (int n = 0; n < 5; n++) begin
            for (int h = 0; h < 2; h++) begin
                checks++;
                if (bus.GNT !== 4'(1 << order[n]) || bus.GIDX !== 2'(order[n])) begin
                    failures++;
                    $display("FAIL rotation[%0d] hold %0d: gnt=%b gidx=%0d expected owner %0d",
                             n, h, bus.GNT, bus.GIDX, order[n]);
                end
                if (h == 0) step();
            end
            bus.REQN = 4'(1 << order[n]);
            step();
            bus.REQN = 4'b0000;
        end
    endtask

    task automatic test_release_idle();
        apply_reset();
        bus.REQN = 4'b1011;
        step();
        checks++;
        if (bus.GNT !== 4'b0100) begin
            failures++;
            $display("FAIL idle_setup: gnt=%b expected 0100", bus.GNT);
        end
        bus.REQN = 4'b1111;
        step();
        checks++;
        if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL release_idle: gnt=%b busy=%b expected 0000/0", bus.GNT, bus.BUSY);
        end
        bus.REQN = 4'b1110;
        step();
        checks++;
        if (bus.GNT !== 4'b0001 || bus.GIDX !== 2'd0) begin
            failures++;
            $display("FAIL wrap_grant: gnt=%b gidx=%0d expected 0001/0", bus.GNT, bus.GIDX);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.REQN = 4'b1011;
        step();
        checks++;
        if (bus.GNT !== 4'b0100) begin
            failures++;
            $display("FAIL areset_setup: gnt=%b expected 0100", bus.GNT);
        end
        #2;
        CD = 1'b1;
        #1;
        checks++;
        if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL areset_drop: gnt=%b busy=%b expected 0000/0", bus.GNT, bus.BUSY);
        end
        model_reset();
        bus.REQN = 4'b0011;
        @(posedge CK);
        #1;
        CD = 1'b0;
        step();
        checks++;
        if (bus.GNT !== 4'b0100 || bus.GIDX !== 2'd2) begin
            failures++;
            $display("FAIL areset_regrant: gnt=%b gidx=%0d expected 0100/2", bus.GNT, bus.GIDX);
        end
    endtask

    task automatic test_ce_freeze();
        apply_reset();
        bus.REQN = 4'b1101;
        step();
        bus.CE = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.REQN = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (bus.ANY !== (bus.REQN != 4'b1111)) begin
                failures++;
                $display("FAIL ce_any[%0d]: any=%b reqn=%b", c, bus.ANY, bus.REQN);
            end
            step();
            checks++;
            if (bus.GNT !== 4'b0010 || bus.GIDX !== 2'd1 || bus.BUSY !== 1'b1) begin
                failures++;
                $display("FAIL ce_freeze[%0d]: gnt=%b gidx=%0d busy=%b expected 0010/1/1",
                         c, bus.GNT, bus.GIDX, bus.BUSY);
            end
        end
        bus.CE   = 1'b1;
        bus.REQN = 4'b1010;
        step();
        checks++;
        if (bus.GNT !== 4'b0100 || bus.GIDX !== 2'd2) begin
            failures++;
            $display("FAIL ce_resume: gnt=%b gidx=%0d expected 0100/2", bus.GNT, bus.GIDX);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] want;
        apply_reset();
        bus.REQN = 4'b1110;
        step();
        bus.REQN = 4'b1100;
        for (int e = 1; e <= 6; e++) begin
            step();
            want = (TIMEOUT_BUILD && e >= 4) ? 4'b0010 : 4'b0001;
            checks++;
            if (bus.GNT !== want) begin
                failures++;
                $display("FAIL timeout edge %0d: gnt=%b expected %b", e, bus.GNT, want);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            logic [3:0] r;
            r = '1;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 99) < 40) r[b] = 1'b0;
            bus.REQN = r;
            bus.CE   = ($urandom_range(0, 9) != 0);
            #1;
            checks++;
            if (bus.ANY !== (r != 4'b1111)) begin
                failures++;
                $display("FAIL rand_any[%0d]: any=%b reqn=%b", c, bus.ANY, r);
            end
            step();
            checks++;
            if (bus.GNT !== exp_gnt() || bus.BUSY !== (m_owner >= 0) ||
                (m_owner >= 0 && bus.GIDX !== 2'(m_owner))) begin
                failures++;
                $display("FAIL rand_grant[%0d]: gnt=%b busy=%b gidx=%0d expected gnt=%b owner=%0d",
                         c, bus.GNT, bus.BUSY, bus.GIDX, exp_gnt(), m_owner);
            end
            #2;
        end
        bus.CE = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_rotation();
        test_release_idle();
        test_async_reset();
        test_ce_freeze();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
